// File: rtl/amb_diff_mask.sv
// Per-pixel foreground classifier: ambient-corrected RGB distance, threshold,
// horizontal 3-tap majority clean-up and per-frame count / bounding box.
module amb_diff_mask #(
  parameter int FRAME_W = 640,
  parameter int FRAME_H = 480
) (
  input  logic        clk_25,
  input  logic        reset,
  input  logic        valid_i,
  input  logic [9:0]  syncX_i,
  input  logic [9:0]  syncY_i,
  input  logic [4:0]  DVI_R_i,
  input  logic [5:0]  DVI_G_i,
  input  logic [4:0]  DVI_B_i,
  input  logic [4:0]  CCD_R_i,
  input  logic [5:0]  CCD_G_i,
  input  logic [4:0]  CCD_B_i,
  input  logic [7:0]  amb_shift_r_i,
  input  logic [7:0]  amb_shift_g_i,
  input  logic [7:0]  amb_shift_b_i,
  input  logic [31:0] threshold_i,
  output logic        valid_o,
  output logic [9:0]  syncX_o,
  output logic [9:0]  syncY_o,
  output logic        mask_o,
  output logic [18:0] fg_count_o,
  output logic [9:0]  bbox_xmin_o,
  output logic [9:0]  bbox_xmax_o,
  output logic [9:0]  bbox_ymin_o,
  output logic [9:0]  bbox_ymax_o,
  output logic        bbox_valid_o,
  output logic        frame_done_o
);

  localparam logic [9:0] X_LAST = 10'(FRAME_W - 1);
  localparam logic [9:0] Y_LAST = 10'(FRAME_H - 1);

  function automatic logic [7:0] residue(input logic [7:0] a, input logic [7:0] b,
                                         input logic [7:0] amb);
    logic [7:0] d;
    d = (a > b) ? a - b : b - a;
    return (d > amb) ? d - amb : 8'd0;
  endfunction

  function automatic logic majority(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  // Frame parameters, captured on the first pixel of each frame.
  logic [7:0]  amb_r, amb_g, amb_b;
  logic [31:0] thr;

  // NOTE: sequential state is always written with non-blocking assignments so
  // every register samples pre-edge values regardless of process order.
  always_ff @(posedge clk_25 or negedge reset) begin
    if (!reset) begin
      amb_r <= '0;
      amb_g <= '0;
      amb_b <= '0;
      thr   <= '0;
    end else if (valid_i && syncX_i == 10'd0 && syncY_i == 10'd0) begin
      amb_r <= amb_shift_r_i;
      amb_g <= amb_shift_g_i;
      amb_b <= amb_shift_b_i;
      thr   <= threshold_i;
    end
  end

  // S1: expand RGB565 to 8 bits per channel.
  logic       s1_valid;
  logic [9:0] s1_x, s1_y;
  logic [7:0] s1_dr, s1_dg, s1_db, s1_cr, s1_cg, s1_cb;

  always_ff @(posedge clk_25 or negedge reset) begin
    if (!reset) begin
      s1_valid <= 1'b0;
      s1_x  <= '0;
      s1_y  <= '0;
      s1_dr <= '0;
      s1_dg <= '0;
      s1_db <= '0;
      s1_cr <= '0;
      s1_cg <= '0;
      s1_cb <= '0;
    end else begin
      s1_valid <= valid_i;
      if (valid_i) begin
        s1_x  <= syncX_i;
        s1_y  <= syncY_i;
        s1_dr <= {DVI_R_i, 3'b000};
        s1_dg <= {DVI_G_i, 2'b00};
        s1_db <= {DVI_B_i, 3'b000};
        s1_cr <= {CCD_R_i, 3'b000};
        s1_cg <= {CCD_G_i, 2'b00};
        s1_cb <= {CCD_B_i, 3'b000};
      end
    end
  end

  // S2: absolute difference with the ambient shift removed.
  logic       s2_valid;
  logic [9:0] s2_x, s2_y;
  logic [7:0] s2_rr, s2_rg, s2_rb;

  always_ff @(posedge clk_25 or negedge reset) begin
    if (!reset) begin
      s2_valid <= 1'b0;
      s2_x  <= '0;
      s2_y  <= '0;
      s2_rr <= '0;
      s2_rg <= '0;
      s2_rb <= '0;
    end else begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_x  <= s1_x;
        s2_y  <= s1_y;
        s2_rr <= residue(s1_dr, s1_cr, amb_r);
        s2_rg <= residue(s1_dg, s1_cg, amb_g);
        s2_rb <= residue(s1_db, s1_cb, amb_b);
      end
    end
  end

  // S3: squared distance against the threshold rescaled by 16.
  logic [15:0] sq_r, sq_g, sq_b;
  logic [17:0] fd2;
  logic        raw;

  always_comb begin
    sq_r = s2_rr * s2_rr;
    sq_g = s2_rg * s2_rg;
    sq_b = s2_rb * s2_rb;
    fd2  = {2'b00, sq_r} + {2'b00, sq_g} + {2'b00, sq_b};
    raw  = {18'd0, fd2} > {thr, 4'b0000};
  end

  logic       s3_valid, s3_raw;
  logic [9:0] s3_x, s3_y;

  always_ff @(posedge clk_25 or negedge reset) begin
    if (!reset) begin
      s3_valid <= 1'b0;
      s3_raw   <= 1'b0;
      s3_x     <= '0;
      s3_y     <= '0;
    end else begin
      s3_valid <= s2_valid;
      if (s2_valid) begin
        s3_raw <= raw;
        s3_x   <= s2_x;
        s3_y   <= s2_y;
      end
    end
  end

  // Filter window: w1 = raw[x-1], w2 = raw[x-2] of the current line.
  logic       w1, w2, flush_pend;
  logic [9:0] flush_y;
  logic       emit, emit_mask;
  logic [9:0] emit_x, emit_y;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    emit      = 1'b0;
    emit_mask = 1'b0;
    emit_x    = '0;
    emit_y    = '0;
    if (s3_valid && s3_x != 10'd0) begin
      emit      = 1'b1;
      emit_mask = majority(w2, w1, s3_raw);
      emit_x    = s3_x - 10'd1;
      emit_y    = s3_y;
    end else if (flush_pend) begin
      emit      = 1'b1;
      emit_mask = w2 & w1;
      emit_x    = X_LAST;
      emit_y    = flush_y;
    end
  end

  always_ff @(posedge clk_25 or negedge reset) begin
    if (!reset) begin
      w1         <= 1'b0;
      w2         <= 1'b0;
      flush_pend <= 1'b0;
      flush_y    <= '0;
      valid_o    <= 1'b0;
      mask_o     <= 1'b0;
      syncX_o    <= '0;
      syncY_o    <= '0;
    end else begin
      if (s3_valid) begin
        w1 <= s3_raw;
        w2 <= (s3_x == 10'd0) ? 1'b0 : w1;
      end
      flush_pend <= s3_valid && s3_x == X_LAST;
      if (s3_valid && s3_x == X_LAST) flush_y <= s3_y;
      valid_o <= emit;
      mask_o  <= emit & emit_mask;
      if (emit) begin
        syncX_o <= emit_x;
        syncY_o <= emit_y;
      end
    end
  end

  // Frame statistics, accumulated from the filtered output stream.
  logic [18:0] acc_count, nxt_count;
  logic [9:0]  acc_xmin, acc_xmax, acc_ymin, acc_ymax;
  logic [9:0]  nxt_xmin, nxt_xmax, nxt_ymin, nxt_ymax;
  logic        hit, last_px;

  always_comb begin
    hit       = valid_o & mask_o;
    last_px   = valid_o && syncX_o == X_LAST && syncY_o == Y_LAST;
    nxt_count = acc_count + 19'(hit);
    nxt_xmin  = (hit && syncX_o < acc_xmin) ? syncX_o : acc_xmin;
    nxt_xmax  = (hit && syncX_o > acc_xmax) ? syncX_o : acc_xmax;
    nxt_ymin  = (hit && syncY_o < acc_ymin) ? syncY_o : acc_ymin;
    nxt_ymax  = (hit && syncY_o > acc_ymax) ? syncY_o : acc_ymax;
  end

  always_ff @(posedge clk_25 or negedge reset) begin
    if (!reset) begin
      acc_count    <= '0;
      acc_xmin     <= X_LAST;
      acc_xmax     <= '0;
      acc_ymin     <= Y_LAST;
      acc_ymax     <= '0;
      fg_count_o   <= '0;
      bbox_xmin_o  <= '0;
      bbox_xmax_o  <= '0;
      bbox_ymin_o  <= '0;
      bbox_ymax_o  <= '0;
      bbox_valid_o <= 1'b0;
      frame_done_o <= 1'b0;
    end else begin
      frame_done_o <= last_px;
      if (last_px) begin
        fg_count_o   <= nxt_count;
        bbox_valid_o <= nxt_count != 19'd0;
        bbox_xmin_o  <= (nxt_count != 19'd0) ? nxt_xmin : 10'd0;
        bbox_xmax_o  <= (nxt_count != 19'd0) ? nxt_xmax : 10'd0;
        bbox_ymin_o  <= (nxt_count != 19'd0) ? nxt_ymin : 10'd0;
        bbox_ymax_o  <= (nxt_count != 19'd0) ? nxt_ymax : 10'd0;
        acc_count    <= '0;
        acc_xmin     <= X_LAST;
        acc_xmax     <= '0;
        acc_ymin     <= Y_LAST;
        acc_ymax     <= '0;
      end else begin
        acc_count <= nxt_count;
        acc_xmin  <= nxt_xmin;
        acc_xmax  <= nxt_xmax;
        acc_ymin  <= nxt_ymin;
        acc_ymax  <= nxt_ymax;
      end
    end
  end

endmodule

// File: tb/tb_amb_diff_mask.sv
// Scoreboard bench for amb_diff_mask on a reduced 32x8 frame: directed frames
// push expected mask beats and frame stats; a monitor pops and compares.
module tb_amb_diff_mask;
  localparam int W = 32;
  localparam int H = 8;

  logic        clk_25 = 1'b0;
  logic        reset  = 1'b0;
  logic        valid_i = 1'b0;
  logic [9:0]  syncX_i = '0, syncY_i = '0;
  logic [4:0]  DVI_R_i = '0, DVI_B_i = '0, CCD_R_i = '0, CCD_B_i = '0;
  logic [5:0]  DVI_G_i = '0, CCD_G_i = '0;
  logic [7:0]  amb_shift_r_i = '0, amb_shift_g_i = '0, amb_shift_b_i = '0;
  logic [31:0] threshold_i = '0;
  logic        valid_o, mask_o, bbox_valid_o, frame_done_o;
  logic [9:0]  syncX_o, syncY_o, bbox_xmin_o, bbox_xmax_o, bbox_ymin_o, bbox_ymax_o;
  logic [18:0] fg_count_o;

  amb_diff_mask #(.FRAME_W(W), .FRAME_H(H)) dut (
    .clk_25(clk_25), .reset(reset), .valid_i(valid_i),
    .syncX_i(syncX_i), .syncY_i(syncY_i),
    .DVI_R_i(DVI_R_i), .DVI_G_i(DVI_G_i), .DVI_B_i(DVI_B_i),
    .CCD_R_i(CCD_R_i), .CCD_G_i(CCD_G_i), .CCD_B_i(CCD_B_i),
    .amb_shift_r_i(amb_shift_r_i), .amb_shift_g_i(amb_shift_g_i),
    .amb_shift_b_i(amb_shift_b_i), .threshold_i(threshold_i),
    .valid_o(valid_o), .syncX_o(syncX_o), .syncY_o(syncY_o), .mask_o(mask_o),
    .fg_count_o(fg_count_o), .bbox_xmin_o(bbox_xmin_o), .bbox_xmax_o(bbox_xmax_o),
    .bbox_ymin_o(bbox_ymin_o), .bbox_ymax_o(bbox_ymax_o),
    .bbox_valid_o(bbox_valid_o), .frame_done_o(frame_done_o)
  );

  always #20 clk_25 = ~clk_25;

  int cyc = 0;
  always @(posedge clk_25) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {int x; int y; bit mask; int cyc;} pix_exp_t;
  typedef struct {int count; int xmin; int xmax; int ymin; int ymax; bit bv;} stat_exp_t;
  typedef struct {
    int pat; int chan; logic [31:0] thr; logic [7:0] ar; logic [7:0] ag; logic [7:0] ab;
    bit fg; bit gaps; bit rst_mid;
    int cnt; int xmin; int xmax; int ymin; int ymax;
  } frame_t;

  pix_exp_t  pix_q[$];
  stat_exp_t stat_q[$];
  frame_t    frames[7];

  // Which pixels carry a colour difference of 128 in the 8-bit domain.
  function automatic bit diff_at(input int pat, input int x, input int y);
    case (pat)
      1: return (x >= 4 && x <= 11 && y >= 2 && y <= 4);
      2: return (x == 12 && y == 1) || ((x == 12 || x == 13) && y == 3) ||
                ((x == 30 || x == 31) && y == 5) || (x == 0 && y == 6);
      default: return 1'b0;
    endcase
  endfunction

  function automatic bit raw_exp(input int f, input int x, input int y);
    if (x < 0 || x >= W) return 1'b0;
    return frames[f].fg && diff_at(frames[f].pat, x, y);
  endfunction

  function automatic bit exp_mask(input int f, input int x, input int y);
    bit a, b, c;
    a = raw_exp(f, x - 1, y);
    b = raw_exp(f, x, y);
    c = raw_exp(f, x + 1, y);
    return (a + b + c) >= 2;
  endfunction

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk_25); #1;
      valid_i = 1'b0;
    end
  endtask

  task automatic drive_pixel(input int f, input int x, input int y);
    pix_exp_t  pe;
    stat_exp_t se;
    int r, g, b;
    @(posedge clk_25); #1;
    r = $urandom_range(0, 15);
    g = $urandom_range(0, 31);
    b = $urandom_range(0, 15);
    valid_i = 1'b1;
    syncX_i = 10'(x);
    syncY_i = 10'(y);
    DVI_R_i = 5'(r); DVI_G_i = 6'(g); DVI_B_i = 5'(b);
    CCD_R_i = 5'(r); CCD_G_i = 6'(g); CCD_B_i = 5'(b);
    if (diff_at(frames[f].pat, x, y)) begin
      case (frames[f].chan)
        0: CCD_R_i = 5'(r + 16);
        1: CCD_G_i = 6'(g + 32);
        default: CCD_B_i = 5'(b + 16);
      endcase
    end
    // Frame parameters only matter on the origin beat; elsewhere drive noise.
    if (x == 0 && y == 0) begin
      amb_shift_r_i = frames[f].ar;
      amb_shift_g_i = frames[f].ag;
      amb_shift_b_i = frames[f].ab;
      threshold_i   = frames[f].thr;
    end else begin
      amb_shift_r_i = 8'($urandom);
      amb_shift_g_i = 8'($urandom);
      amb_shift_b_i = 8'($urandom);
      threshold_i   = $urandom;
    end
    if (x >= 1) begin
      pe = '{x - 1, y, exp_mask(f, x - 1, y), cyc + 4};
      pix_q.push_back(pe);
    end
    if (x == W - 1) begin
      pe = '{W - 1, y, exp_mask(f, W - 1, y), cyc + 5};
      pix_q.push_back(pe);
      if (y == H - 1) begin
        se = '{frames[f].cnt, frames[f].xmin, frames[f].xmax,
               frames[f].ymin, frames[f].ymax, frames[f].cnt != 0};
        stat_q.push_back(se);
      end
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, " valid_o"}, valid_o, 0);
    check({tag, " mask_o"}, mask_o, 0);
    check({tag, " syncX_o"}, syncX_o, 0);
    check({tag, " syncY_o"}, syncY_o, 0);
    check({tag, " fg_count_o"}, fg_count_o, 0);
    check({tag, " bbox_xmin_o"}, bbox_xmin_o, 0);
    check({tag, " bbox_xmax_o"}, bbox_xmax_o, 0);
    check({tag, " bbox_ymin_o"}, bbox_ymin_o, 0);
    check({tag, " bbox_ymax_o"}, bbox_ymax_o, 0);
    check({tag, " bbox_valid_o"}, bbox_valid_o, 0);
    check({tag, " frame_done_o"}, frame_done_o, 0);
  endtask

  task automatic mid_frame_reset();
    @(posedge clk_25); #1;
    reset   = 1'b0;
    valid_i = 1'b0;
    pix_q.delete();
    stat_q.delete();
    repeat (2) @(negedge clk_25);
    check_outputs_zero("mid reset");
    @(posedge clk_25); #1;
    reset = 1'b1;
  endtask

  // Monitor: pops one expectation per output beat and per stats update.
  always @(negedge clk_25) begin
    pix_exp_t  pe;
    stat_exp_t se;
    if (valid_o) begin
      if (pix_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected valid_o: pixel (%0d,%0d) with no expectation", syncX_o, syncY_o);
      end else begin
        pe = pix_q.pop_front();
        check("syncX_o", syncX_o, pe.x);
        check("syncY_o", syncY_o, pe.y);
        check($sformatf("mask_o(%0d,%0d)", pe.x, pe.y), mask_o, pe.mask);
        check($sformatf("latency(%0d,%0d)", pe.x, pe.y), cyc, pe.cyc);
      end
    end
    if (frame_done_o) begin
      if (stat_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected frame_done_o: fg_count_o=%0d, no frame expected", fg_count_o);
      end else begin
        se = stat_q.pop_front();
        check("fg_count_o", fg_count_o, se.count);
        check("bbox_xmin_o", bbox_xmin_o, se.xmin);
        check("bbox_xmax_o", bbox_xmax_o, se.xmax);
        check("bbox_ymin_o", bbox_ymin_o, se.ymin);
        check("bbox_ymax_o", bbox_ymax_o, se.ymax);
        check("bbox_valid_o", bbox_valid_o, se.bv);
      end
    end
  end

  initial begin
    bit aborted;
    //            pat chan thr   ar   ag   ab  fg gaps rst  cnt xmin xmax ymin ymax
    frames[0] = '{0, 0, 32'd0,    8'd0,   8'd0,   8'd0, 0, 0, 0, 0,  0,  0,  0, 0};
    frames[1] = '{1, 0, 32'd100,  8'd0,   8'd0,   8'd0, 1, 0, 0, 24, 4,  11, 2, 4};
    frames[2] = '{1, 0, 32'd0,    8'd128, 8'd0,   8'd0, 0, 0, 0, 0,  0,  0,  0, 0};
    frames[3] = '{2, 1, 32'd1023, 8'd0,   8'd0,   8'd0, 1, 0, 0, 4,  12, 31, 3, 5};
    frames[4] = '{1, 0, 32'd1024, 8'd0,   8'd0,   8'd0, 0, 0, 0, 0,  0,  0,  0, 0};
    frames[5] = '{1, 0, 32'd100,  8'd0,   8'd0,   8'd0, 1, 1, 1, 24, 4,  11, 2, 4};
    frames[6] = '{1, 2, 32'd100,  8'd0,   8'd200, 8'd0, 1, 1, 0, 24, 4,  11, 2, 4};

    repeat (3) @(negedge clk_25);
    check_outputs_zero("reset");
    @(posedge clk_25); #1;
    reset = 1'b1;
    idle(2);

    for (int f = 0; f < 7; f++) begin
      aborted = 1'b0;
      for (int y = 0; y < H && !aborted; y++) begin
        for (int x = 0; x < W && !aborted; x++) begin
          if (frames[f].rst_mid && x == W / 2 && y == H / 2) begin
            mid_frame_reset();
            aborted = 1'b1;
          end else begin
            if (frames[f].gaps) idle($urandom_range(0, 3));
            drive_pixel(f, x, y);
          end
        end
      end
    end
    idle(1);

    for (int i = 0; i < 100 && (pix_q.size() != 0 || stat_q.size() != 0); i++)
      @(posedge clk_25);
    repeat (2) @(negedge clk_25);
    check("pixel scoreboard drained", pix_q.size(), 0);
    check("frame scoreboard drained", stat_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
